// File: rtl/amx_pkg.sv
// Shared constants and types for the add-multiply-xor feeder.
// Holds the pipeline latencies, the operand bundle and a token popcount helper.
package amx_pkg;

  localparam int AMX_WIDTH    = 16;
  localparam int AMX_CORE_LAT = 3;
  localparam int AMX_FEED_LAT = 4;

  typedef struct packed {
    logic [AMX_WIDTH-1:0] a;
    logic [AMX_WIDTH-1:0] b;
    logic [AMX_WIDTH-1:0] c;
    logic [AMX_WIDTH-1:0] d;
  } amx_operands_t;

  function automatic logic [2:0] amx_popcnt(
    input logic [AMX_FEED_LAT-1:0] v
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < AMX_FEED_LAT; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/amx_result_fifo.sv
// Synchronous result FIFO; pop from empty is ignored, pointers wrap mod DEPTH.
// Ports: clk, rst, push/push_data, pop/pop_data, count, empty, full.
module amx_result_fifo
  import amx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;

  // Head is forced to zero when empty so stale entries never show.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/amx_operand_feeder.sv
// Valid/ready feeder and credit-protected result collector for ((a+b)*c)^d.
// Ports: in_* handshake+operands, core_* drives/core_out return, out_* FIFO head.
// Optional AMX_FEEDER_PERF_EN adds perf_accepts/perf_stalls counters.
module amx_operand_feeder
  import amx_pkg::*;
#(
  parameter int WIDTH      = AMX_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic [WIDTH-1:0] core_c,
  output logic [WIDTH-1:0] core_d,
  input  logic [WIDTH-1:0] core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef AMX_FEEDER_PERF_EN
  ,
  output logic [31:0]      perf_accepts,
  output logic [31:0]      perf_stalls
`endif
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int OCCW = $clog2(FIFO_DEPTH) + 3;

  logic [WIDTH-1:0]        c_s1;
  logic [WIDTH-1:0]        d_s1;
  logic [WIDTH-1:0]        d_s2;
  logic [AMX_FEED_LAT-1:0] vld;
  logic                    accept;
  logic [CNTW-1:0]         fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [OCCW-1:0]         occ;

  assign accept = in_valid && in_ready;

  // Every accepted tuple holds a credit from accept until it leaves
  // the FIFO, so the count of tokens in flight plus stored results
  // bounds what the FIFO can ever be asked to hold.
  assign occ = OCCW'(fifo_count) + OCCW'(amx_popcnt(vld));
  assign in_ready = !rst && (occ < OCCW'(FIFO_DEPTH));

  // Operand capture only on accept; the skew chain itself
  // advances every cycle so c and d meet their core stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_a <= '0;
      core_b <= '0;
      c_s1   <= '0;
      d_s1   <= '0;
    end else if (accept) begin
      core_a <= in_a;
      core_b <= in_b;
      c_s1   <= in_c;
      d_s1   <= in_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_c <= '0;
      d_s2   <= '0;
      core_d <= '0;
    end else begin
      core_c <= c_s1;
      d_s2   <= d_s1;
      core_d <= d_s2;
    end
  end

  // vld[CORE_LAT] marks that core_out now carries a live result.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= {vld[AMX_FEED_LAT-2:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(vld[AMX_CORE_LAT] && fifo_full))
        else $error("result fifo overflow");
    end
  end

  amx_result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld[AMX_CORE_LAT]),
    .push_data (core_out),
    .pop       (out_ready),
    .pop_data  (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;

`ifdef AMX_FEEDER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_accepts <= '0;
      perf_stalls  <= '0;
    end else begin
      if (accept) begin
        perf_accepts <= perf_accepts + 32'd1;
      end
      if (in_valid && !in_ready) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
